// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_pkg
//  Brief    : Shared AHB encodings and bridge state type for ahb_apb_bridge_gen2
//  Revision : 1.0  initial release
// ============================================================================
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_slave_decode.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_decode
//  Brief    : Maps an AHB address onto a contiguous window of NSLV APB slaves
//  Revision : 1.0  initial release
// ============================================================================
module apb_slave_decode #(
  parameter int                ADDR_W     = 32,
  parameter int                NSLV       = 4,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                REGION_LG2 = 24
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [NSLV-1:0]   o_sel
);

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_idx;

  // The base comparison guards against the subtraction wrapping below BASE.
  assign w_off = i_addr - BASE;
  assign w_idx = w_off >> REGION_LG2;
  assign o_hit = (i_addr >= BASE) && (w_idx < ADDR_W'(NSLV));

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      o_sel[i] = o_hit && (w_idx == ADDR_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_apb_bridge_gen2.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_bridge_gen2
//  Brief    : AHB slave to NSLV APB3 peripherals with wait, error and timeout
//  Revision : 1.0  initial release
// ============================================================================
module ahb_apb_bridge_gen2
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NSLV       = 4,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                REGION_LG2 = 24,
  parameter int                TIMEOUT    = 255
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  bridge_state_t     r_state;
  logic [NSLV-1:0]   r_pselx;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_hrdata;
  logic [1:0]        r_hresp;
  logic              r_hreadyout;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_valid;
  logic              w_hit;
  logic [NSLV-1:0]   w_sel;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_timeout;
  logic              w_unused;

  apb_slave_decode #(
    .ADDR_W     (ADDR_W),
    .NSLV       (NSLV),
    .BASE       (BASE),
    .REGION_LG2 (REGION_LG2)
  ) u_decode (
    .i_addr (Haddr),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  // Only NONSEQ/SEQ carry a transfer; BUSY is treated like IDLE.
  assign w_valid    = Hreadyin & Htrans[1] & r_hreadyout;
  assign w_unused   = Htrans[0];
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == CNT_W'(TIMEOUT));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state     <= ST_IDLE;
      r_pselx     <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_hrdata    <= '0;
      r_hresp     <= HRESP_OKAY;
      r_hreadyout <= 1'b1;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_hreadyout <= 1'b0;
            if (w_hit) begin
              r_pselx  <= w_sel;
              r_paddr  <= Haddr;
              r_pwrite <= Hwrite;
              r_state  <= ST_SETUP;
            end else begin
              r_hresp <= HRESP_ERROR;
              r_state <= ST_ERR1;
            end
          end
        end
        ST_SETUP: begin
          r_pwdata  <= Hwdata;
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (Pready) begin
            r_pselx   <= '0;
            r_penable <= 1'b0;
            if (Pslverr) begin
              r_hresp <= HRESP_ERROR;
              r_state <= ST_ERR1;
            end else begin
              if (!r_pwrite) r_hrdata <= Prdata;
              r_hreadyout <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_hresp   <= HRESP_ERROR;
            r_state   <= ST_ERR1;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        ST_ERR1: begin
          r_hreadyout <= 1'b1;
          r_state     <= ST_ERR2;
        end
        ST_ERR2: begin
          r_hresp <= HRESP_OKAY;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Hwdata is the AHB data phase of the accepted write, so it is already
  // stable during SETUP; forward it there and hold the captured copy after.
  assign Pwdata    = (r_state == ST_SETUP) ? Hwdata : r_pwdata;
  assign Pselx     = r_pselx;
  assign Penable   = r_penable;
  assign Pwrite    = r_pwrite;
  assign Paddr     = r_paddr;
  assign Hrdata    = r_hrdata;
  assign Hresp     = r_hresp;
  assign Hreadyout = r_hreadyout;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge_gen2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_apb_bridge_gen2
//  Brief    : Scoreboard bench for ahb_apb_bridge_gen2 with a simple APB slave
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_apb_bridge_gen2;
  import ahb_apb_pkg::*;

  localparam logic [31:0] c_base = 32'h8000_0000;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_gen2 u_dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .Pready    (Pready),
    .Pslverr   (Pslverr)
  );

  // APB slave model: Pready rises after cfg_waits low ACCESS cycles.
  int          cfg_waits = 0;
  logic        cfg_stuck = 1'b0;
  logic        cfg_serr  = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  int          wcnt = 0;
  int          cyc  = 0;

  always @(posedge Hclk) begin
    cyc <= cyc + 1;
    if (!Penable)               wcnt <= 0;
    else if (!Pready)           wcnt <= wcnt + 1;
  end

  assign Pready  = !cfg_stuck && (wcnt >= cfg_waits);
  assign Pslverr = cfg_serr;
  assign Prdata  = cfg_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lowcyc;
    int          encyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rd = 32'h0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int waits, input logic serr, input logic stuck, input string tag);
    exp_t        e;
    exp_t        g;
    logic        hit;
    logic [31:0] off;
    logic [3:0]  esel;
    logic        bad;
    logic [1:0]  prev_hresp;
    int          lowc;
    int          enc;
    off  = addr - c_base;
    hit  = (addr >= c_base) && (off[31:24] < 8'd4);
    esel = hit ? (4'b0001 << off[25:24]) : 4'b0000;
    e.err = !hit || serr || stuck;
    if (!hit) begin
      e.lowcyc = 1;   e.encyc = 0;
    end else if (stuck) begin
      e.lowcyc = 257; e.encyc = 255;
    end else begin
      e.lowcyc = waits + (serr ? 3 : 2);
      e.encyc  = waits + 1;
    end
    if (!wr && !e.err) model_rd = data;
    e.rdata = model_rd;
    sb.push_back(e);

    cfg_waits = waits;
    cfg_serr  = serr;
    cfg_stuck = stuck;
    cfg_rdata = wr ? 32'hA5A5_5A5A : data;
    Htrans = HTRANS_NONSEQ;
    Haddr  = addr;
    Hwrite = wr;
    @(posedge Hclk); #1;
    Htrans = HTRANS_IDLE;
    Hwdata = wr ? data : 32'h0;
    @(negedge Hclk);
    if (hit) begin
      check({tag, "_setup_sel"}, {28'h0, Pselx}, {28'h0, esel});
      check({tag, "_setup_en"}, {31'h0, Penable}, 32'h0);
      check({tag, "_setup_addr"}, Paddr, addr);
      check({tag, "_setup_wr"}, {31'h0, Pwrite}, {31'h0, wr});
      if (wr) check({tag, "_setup_wdata"}, Pwdata, data);
    end else begin
      check({tag, "_err1_sel"}, {28'h0, Pselx}, 32'h0);
      check({tag, "_err1_resp"}, {30'h0, Hresp}, {30'h0, HRESP_ERROR});
    end
    check({tag, "_t1_ready"}, {31'h0, Hreadyout}, 32'h0);

    lowc = 0; enc = 0; bad = 1'b0; prev_hresp = Hresp;
    for (int c = 0; c < 400 && Hreadyout !== 1'b1; c++) begin
      lowc++;
      if (Penable) enc++;
      if ((Penable && Pselx == 4'b0) || $countones(Pselx) > 1) bad = 1'b1;
      prev_hresp = Hresp;
      @(negedge Hclk);
    end
    check({tag, "_done_ready"}, {31'h0, Hreadyout}, 32'h1);
    check({tag, "_apb_inv"}, {31'h0, bad}, 32'h0);
    check({tag, "_done_sel"}, {28'h0, Pselx}, 32'h0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      g = sb.pop_front();
      check({tag, "_lowcyc"}, lowc, g.lowcyc);
      check({tag, "_encyc"}, enc, g.encyc);
      check({tag, "_resp"}, {30'h0, Hresp}, g.err ? {30'h0, HRESP_ERROR} : {30'h0, HRESP_OKAY});
      check({tag, "_rdata"}, Hrdata, g.rdata);
      if (g.err) begin
        check({tag, "_err1_prev"}, {30'h0, prev_hresp}, {30'h0, HRESP_ERROR});
        @(negedge Hclk);
        check({tag, "_post_resp"}, {30'h0, Hresp}, {30'h0, HRESP_OKAY});
        check({tag, "_post_ready"}, {31'h0, Hreadyout}, 32'h1);
      end
    end
  endtask

  initial begin
    int t3;
    Hresetn  = 1'b0;
    Hwrite   = 1'b0;
    Hreadyin = 1'b1;
    Htrans   = HTRANS_IDLE;
    Haddr    = 32'h0;
    Hwdata   = 32'h0;
    @(negedge Hclk);
    check("rst_sel", {28'h0, Pselx}, 32'h0);
    check("rst_en", {31'h0, Penable}, 32'h0);
    check("rst_ready", {31'h0, Hreadyout}, 32'h1);
    check("rst_resp", {30'h0, Hresp}, 32'h0);
    check("rst_rdata", Hrdata, 32'h0);
    check("rst_paddr", Paddr, 32'h0);
    check("rst_pwdata", Pwdata, 32'h0);
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    xfer(1'b1, 32'h8100_0010, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, "wr_s1");
    xfer(1'b0, 32'h8300_0004, 32'h1234_5678, 3, 1'b0, 1'b0, "rd_s3");
    xfer(1'b0, 32'h9000_0000, 32'h0,         0, 1'b0, 1'b0, "miss");
    xfer(1'b1, 32'h8000_0100, 32'hCAFE_F00D, 0, 1'b1, 1'b0, "slverr");
    xfer(1'b0, 32'h8200_0000, 32'h5555_AAAA, 0, 1'b0, 1'b1, "tmo");
    xfer(1'b0, 32'h7FFF_FFFC, 32'h0,         0, 1'b0, 1'b0, "below_base");
    xfer(1'b0, 32'h83FF_FFFC, 32'h0BAD_F00D, 1, 1'b0, 1'b0, "top_edge");
    xfer(1'b0, 32'h8400_0000, 32'h0,         0, 1'b0, 1'b0, "past_top");

    // Back-to-back: second address phase presented in the first's T3.
    xfer(1'b1, 32'h8000_0020, 32'h1111_0000, 0, 1'b0, 1'b0, "b2b0");
    t3 = cyc;
    cfg_waits = 5;
    Htrans = HTRANS_NONSEQ;
    Haddr  = 32'h8200_0008;
    Hwrite = 1'b1;
    @(posedge Hclk); #1;
    Htrans = HTRANS_IDLE;
    Hwdata = 32'h2222_0000;
    @(negedge Hclk);
    check("b2b1_setup_cycle", cyc - t3, 32'd1);
    check("b2b1_setup_sel", {28'h0, Pselx}, 32'h4);
    check("b2b1_setup_addr", Paddr, 32'h8200_0008);
    @(negedge Hclk);
    check("b2b1_access_en", {31'h0, Penable}, 32'h1);
    #2 Hresetn = 1'b0;
    #1;
    check("async_rst_sel", {28'h0, Pselx}, 32'h0);
    check("async_rst_en", {31'h0, Penable}, 32'h0);
    check("async_rst_ready", {31'h0, Hreadyout}, 32'h1);
    check("async_rst_rdata", Hrdata, 32'h0);
    model_rd = 32'h0;
    @(posedge Hclk); #1;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    xfer(1'b0, 32'h8000_0040, 32'h7777_8888, 0, 1'b0, 1'b0, "post_rst");

    check("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
